dmem_multi_issue_arbiter: RTL and testbench

Registered N-issue round-robin arbiter for the shared data memory. Each cycle it selects up to NPORTS core requests, with no two selected requests targeting the same word. It drives one grant per memory port, one cycle later. Successor to the combinational dual-issue arbiter:
- owns its round-robin pointer;
- honours per-port backpressure;
- adds starvation-forced priority.

---
 rtl/dmem_multi_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_multi_issue_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_multi_issue_arbiter.sv
// Registered N-issue round-robin arbiter for the shared data memory.
// Starved requests win first; same-word requests never share a cycle; grants land one cycle after ack.
module dmem_multi_issue_arbiter #(
  parameter int NCORES       = 4,
  parameter int NPORTS       = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8,
  localparam int CW  = (NCORES > 1) ? $clog2(NCORES) : 1,
  localparam int AW  = ADDR_WIDTH,
  localparam int AGW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCORES-1:0]    req_valid_i,
  input  logic [NCORES*AW-1:0] req_addr_packed_i,
  output logic [NCORES-1:0]    req_ack_o,
  input  logic [NPORTS-1:0]    port_ready_i,
  output logic [NPORTS-1:0]    gnt_valid_o,
  output logic [NPORTS*CW-1:0] gnt_sel_o,
  output logic [NPORTS*AW-1:0] gnt_addr_o,
  output logic [CW-1:0]        rr_ptr_o
);

  logic [CW-1:0]     rr_ptr_reg;
  logic [CW-1:0]     rr_ptr_next;
  logic [AGW-1:0]    age_reg [NCORES];
  logic [AW-1:0]     req_addr [NCORES];
  logic [NCORES-1:0] starved;
  logic [NCORES-1:0] ack_mask;

  logic [CW-1:0]     acc_core [NPORTS];
  logic [AW-1:0]     acc_addr [NPORTS];
  logic [NPORTS-1:0] port_assign;
  logic [CW-1:0]     port_sel_next [NPORTS];
  logic [AW-1:0]     port_addr_next [NPORTS];

  logic [NPORTS-1:0] gnt_valid_reg;
  logic [CW-1:0]     gnt_sel_reg [NPORTS];
  logic [AW-1:0]     gnt_addr_reg [NPORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign req_addr[gi] = req_addr_packed_i[gi*AW +: AW];
      assign starved[gi]  = (age_reg[gi] == AGW'(STARVE_LIMIT));
    end
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      assign gnt_sel_o[gi*CW +: CW]  = gnt_sel_reg[gi];
      assign gnt_addr_o[gi*AW +: AW] = gnt_addr_reg[gi];
    end
  endgenerate

  assign req_ack_o   = ack_mask;
  assign gnt_valid_o = gnt_valid_reg;
  assign rr_ptr_o    = rr_ptr_reg;

  // Candidate walk: first NCORES steps visit starved cores by index, the
  // next NCORES steps visit the non-starved cores in round-robin order.
  always_comb begin
    int acc_cnt;
    int slots;
    int idx;
    int rank;
    logic [CW-1:0] idx_c;
    logic hit;
    ack_mask    = '0;
    rr_ptr_next = rr_ptr_reg;
    port_assign = '0;
    acc_cnt     = 0;
    slots       = 0;
    idx         = 0;
    rank        = 0;
    idx_c       = '0;
    hit         = 1'b0;
    for (int s = 0; s < NPORTS; s++) begin
      acc_core[s]       = '0;
      acc_addr[s]       = '0;
      port_sel_next[s]  = '0;
      port_addr_next[s] = '0;
      slots             = slots + int'(port_ready_i[s]);
    end
    if (!rst_i) begin
      for (int j = 0; j < 2*NCORES; j++) begin
        if (j < NCORES) begin
          idx = j;
        end else begin
          idx = int'(rr_ptr_reg) + j - NCORES;
          if (idx >= NCORES) idx = idx - NCORES;
        end
        idx_c = CW'(idx);
        if (req_valid_i[idx_c] && (starved[idx_c] == (j < NCORES)) && (acc_cnt < slots)) begin
          hit = 1'b0;
          for (int s = 0; s < NPORTS; s++) begin
            if ((s < acc_cnt) && (acc_addr[s][AW-1:2] == req_addr[idx_c][AW-1:2])) hit = 1'b1;
          end
          // A same-word candidate is only skipped; later cores still compete.
          if (!hit) begin
            for (int s = 0; s < NPORTS; s++) begin
              if (s == acc_cnt) begin
                acc_core[s] = idx_c;
                acc_addr[s] = req_addr[idx_c];
              end
            end
            ack_mask[idx_c] = 1'b1;
            rr_ptr_next     = (idx == NCORES - 1) ? '0 : CW'(idx + 1);
            acc_cnt         = acc_cnt + 1;
          end
        end
      end
      for (int p = 0; p < NPORTS; p++) begin
        if (port_ready_i[p] && (rank < acc_cnt)) begin
          port_assign[p] = 1'b1;
          for (int s = 0; s < NPORTS; s++) begin
            if (s == rank) begin
              port_sel_next[p]  = acc_core[s];
              port_addr_next[p] = acc_addr[s];
            end
          end
        end
        rank = rank + int'(port_ready_i[p]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg    <= '0;
      gnt_valid_reg <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        gnt_sel_reg[p]  <= '0;
        gnt_addr_reg[p] <= '0;
      end
      for (int i = 0; i < NCORES; i++) age_reg[i] <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      gnt_valid_reg <= port_assign;
      for (int p = 0; p < NPORTS; p++) begin
        if (port_assign[p]) begin
          gnt_sel_reg[p]  <= port_sel_next[p];
          gnt_addr_reg[p] <= port_addr_next[p];
        end
      end
      // Ages saturate at the limit; an ack or a dropped request clears them.
      for (int i = 0; i < NCORES; i++) begin
        if (!req_valid_i[i] || ack_mask[i]) begin
          age_reg[i] <= '0;
        end else if (!starved[i]) begin
          age_reg[i] <= age_reg[i] + AGW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_multi_issue_arbiter.sv
// Scoreboard bench: directed vectors push expected ack/grant records, monitors pop and compare.
module tb_dmem_multi_issue_arbiter;

  typedef struct {
    string       name;
    logic [3:0]  ack;
    logic [2:0]  gv;
    logic [5:0]  sel;
    logic [95:0] addr;
    logic [1:0]  rb;
    logic [1:0]  ra;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 cores, 2 ports, short starvation limit.
  logic         rst_a = 1'b1;
  logic [3:0]   valid_a = '0;
  logic [127:0] addr_a = '0;
  logic [1:0]   ready_a = '0;
  logic [3:0]   ack_a;
  logic [1:0]   gv_a;
  logic [3:0]   sel_a;
  logic [63:0]  ga_a;
  logic [1:0]   rr_a;

  // Instance B: 3 cores, 3 ports, non power-of-two wrap.
  logic         rst_b = 1'b1;
  logic [2:0]   valid_b = '0;
  logic [95:0]  addr_b = '0;
  logic [2:0]   ready_b = '0;
  logic [2:0]   ack_b;
  logic [2:0]   gv_b;
  logic [5:0]   sel_b;
  logic [95:0]  ga_b;
  logic [1:0]   rr_b;

  dmem_multi_issue_arbiter #(.NCORES(4), .NPORTS(2), .ADDR_WIDTH(32), .STARVE_LIMIT(2)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_valid_i(valid_a), .req_addr_packed_i(addr_a),
    .req_ack_o(ack_a), .port_ready_i(ready_a), .gnt_valid_o(gv_a), .gnt_sel_o(sel_a),
    .gnt_addr_o(ga_a), .rr_ptr_o(rr_a));

  dmem_multi_issue_arbiter #(.NCORES(3), .NPORTS(3), .ADDR_WIDTH(32), .STARVE_LIMIT(8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_valid_i(valid_b), .req_addr_packed_i(addr_b),
    .req_ack_o(ack_b), .port_ready_i(ready_b), .gnt_valid_o(gv_b), .gnt_sel_o(sel_b),
    .gnt_addr_o(ga_b), .rr_ptr_o(rr_b));

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t pa;
  exp_t pb;
  logic pa_v = 1'b0;
  logic pb_v = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step_a(input string nm, input logic r, input logic [3:0] v, input logic [127:0] ad,
                        input logic [1:0] rdy, input logic [3:0] ack, input logic [1:0] gv,
                        input logic [3:0] sel, input logic [63:0] ga, input logic [1:0] rb,
                        input logic [1:0] ra);
    exp_t e;
    @(posedge clk); #1;
    rst_a = r; valid_a = v; addr_a = ad; ready_a = rdy;
    e.name = nm; e.ack = ack; e.gv = 3'(gv); e.sel = 6'(sel); e.addr = 96'(ga);
    e.rb = rb; e.ra = ra;
    q_a.push_back(e);
    $display("A %-14s rst=%b valid=%b ready=%b exp_ack=%b exp_gv=%b", nm, r, v, rdy, ack, gv);
  endtask

  task automatic step_b(input string nm, input logic [2:0] v, input logic [95:0] ad,
                        input logic [2:0] rdy, input logic [2:0] ack, input logic [2:0] gv,
                        input logic [5:0] sel, input logic [95:0] ga, input logic [1:0] rb,
                        input logic [1:0] ra);
    exp_t e;
    @(posedge clk); #1;
    valid_b = v; addr_b = ad; ready_b = rdy;
    e.name = nm; e.ack = 4'(ack); e.gv = gv; e.sel = sel; e.addr = ga;
    e.rb = rb; e.ra = ra;
    q_b.push_back(e);
    $display("B %-14s valid=%b ready=%b exp_ack=%b exp_gv=%b", nm, v, rdy, ack, gv);
  endtask

  // Monitor A: grants of the previous record, then ack of the current one.
  initial forever begin
    @(negedge clk);
    if (pa_v) begin
      chk({pa.name, ".gnt_valid"}, 96'(gv_a), 96'(pa.gv));
      chk({pa.name, ".gnt_sel"},   96'(sel_a), 96'(pa.sel));
      chk({pa.name, ".gnt_addr"},  96'(ga_a), pa.addr);
      chk({pa.name, ".rr_after"},  96'(rr_a), 96'(pa.ra));
      pa_v = 1'b0;
    end
    if (q_a.size() > 0) begin
      pa = q_a.pop_front();
      chk({pa.name, ".ack"},       96'(ack_a), 96'(pa.ack));
      chk({pa.name, ".rr_before"}, 96'(rr_a), 96'(pa.rb));
      pa_v = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (pb_v) begin
      chk({pb.name, ".gnt_valid"}, 96'(gv_b), 96'(pb.gv));
      chk({pb.name, ".gnt_sel"},   96'(sel_b), 96'(pb.sel));
      chk({pb.name, ".gnt_addr"},  ga_b, pb.addr);
      chk({pb.name, ".rr_after"},  96'(rr_b), 96'(pb.ra));
      pb_v = 1'b0;
    end
    if (q_b.size() > 0) begin
      pb = q_b.pop_front();
      chk({pb.name, ".ack"},       96'(ack_b), 96'(pb.ack));
      chk({pb.name, ".rr_before"}, 96'(rr_b), 96'(pb.rb));
      pb_v = 1'b1;
    end
  end

  // Request withdrawn without an ack: legal, reported as a warning only.
  initial begin
    logic [3:0] pv;
    logic [3:0] pk;
    pv = '0;
    pk = '0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        for (int i = 0; i < 4; i++) begin
          if (pv[i] && !pk[i] && !valid_a[i])
            $display("protocol warning: core %0d dropped its request without an ack", i);
        end
      end
      pv = valid_a;
      pk = ack_a;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pend;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    step_a("reset_state", 0, 4'b0000, 128'h0, 2'b11, 4'b0000, 2'b00, 4'b0000, 64'h0, 2'd0, 2'd0);
    step_a("rr_pair", 0, 4'b1111, {32'h1C, 32'h18, 32'h14, 32'h10}, 2'b11,
           4'b0011, 2'b11, 4'b0100, {32'h14, 32'h10}, 2'd0, 2'd2);
    step_a("rr_next", 0, 4'b1100, {32'h1C, 32'h18, 32'h14, 32'h10}, 2'b11,
           4'b1100, 2'b11, 4'b1110, {32'h1C, 32'h18}, 2'd2, 2'd0);
    step_a("word_conflict", 0, 4'b0111, {32'h1C, 32'h104, 32'h103, 32'h100}, 2'b11,
           4'b0101, 2'b11, 4'b1000, {32'h104, 32'h100}, 2'd0, 2'd3);
    step_a("set_rr", 0, 4'b1000, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b1000, 2'b01, 4'b1011, {32'h104, 32'h2C}, 2'd3, 2'd0);
    step_a("one_slot", 0, 4'b1111, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b10,
           4'b0001, 2'b10, 4'b0011, {32'h20, 32'h2C}, 2'd0, 2'd1);
    step_a("no_slot", 0, 4'b1110, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b00,
           4'b0000, 2'b00, 4'b0011, {32'h20, 32'h2C}, 2'd1, 2'd1);
    step_a("starved_pair", 0, 4'b1110, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b0110, 2'b11, 4'b1001, {32'h28, 32'h24}, 2'd1, 2'd3);
    step_a("starved_one", 0, 4'b1000, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b1000, 2'b01, 4'b1011, {32'h28, 32'h2C}, 2'd3, 2'd0);
    step_a("skip3_a", 0, 4'b1001, {32'h200, 32'h28, 32'h24, 32'h200}, 2'b11,
           4'b0001, 2'b01, 4'b1000, {32'h28, 32'h200}, 2'd0, 2'd1);
    step_a("skip3_b", 0, 4'b1010, {32'h200, 32'h28, 32'h200, 32'h200}, 2'b11,
           4'b0010, 2'b01, 4'b1001, {32'h28, 32'h200}, 2'd1, 2'd2);
    step_a("starve_win", 0, 4'b1100, {32'h200, 32'h200, 32'h200, 32'h200}, 2'b11,
           4'b1000, 2'b01, 4'b1011, {32'h28, 32'h200}, 2'd2, 2'd0);
    step_a("age_cleared", 0, 4'b1100, {32'h200, 32'h200, 32'h200, 32'h200}, 2'b11,
           4'b0100, 2'b01, 4'b1010, {32'h28, 32'h200}, 2'd0, 2'd3);
    step_a("mid_reset", 1, 4'b1111, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b0000, 2'b00, 4'b0000, 64'h0, 2'd3, 2'd0);
    step_a("post_reset", 0, 4'b1111, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b0011, 2'b11, 4'b0100, {32'h24, 32'h20}, 2'd0, 2'd2);
    step_a("idle_hold", 0, 4'b0000, {32'h2C, 32'h28, 32'h24, 32'h20}, 2'b11,
           4'b0000, 2'b00, 4'b0100, {32'h24, 32'h20}, 2'd2, 2'd2);

    step_b("b_reset_state", 3'b000, 96'h0, 3'b111, 3'b000, 3'b000, 6'b000000, 96'h0, 2'd0, 2'd0);
    step_b("b_single", 3'b010, {32'h0, 32'h40, 32'h0}, 3'b111,
           3'b010, 3'b001, 6'b000001, {32'h0, 32'h0, 32'h40}, 2'd0, 2'd2);
    step_b("b_wrap_all", 3'b111, {32'h58, 32'h54, 32'h50}, 3'b111,
           3'b111, 3'b111, 6'b010010, {32'h54, 32'h50, 32'h58}, 2'd2, 2'd2);
    step_b("b_conflict", 3'b111, {32'h60, 32'h64, 32'h60}, 3'b111,
           3'b110, 3'b011, 6'b010110, {32'h54, 32'h64, 32'h60}, 2'd2, 2'd2);
    step_b("b_gap_port", 3'b111, {32'h78, 32'h74, 32'h70}, 3'b101,
           3'b101, 3'b101, 6'b000110, {32'h70, 32'h64, 32'h78}, 2'd2, 2'd1);

    repeat (3) @(posedge clk);
    #1;
    pend = q_a.size() + q_b.size() + int'(pa_v) + int'(pb_v);
    chk("drain", 96'(pend), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
